pair_sort_net: RTL and testbench

Parametrised, fully pipelined Batcher odd-even merge sorting network for N (key, value) pairs, with a per-vector runtime sort direction and a valid/ready handshake on both sides. This is the next generation of the fixed 8-input ascending sorter. It sits between the pair-parsing front end and the range-merge stage. It accepts one N-wide vector per cycle and emits the sorted vector a fixed number of pipeline stages later.

---
 rtl/pair_sort_net_if.sv | 31 +++
 rtl/pair_sort_net.sv | 136 +++++++++++++
 tb/tb_pair_sort_net.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pair_sort_net_if.sv
// rtl/pair_sort_net_if.sv - vector handshake bundle between pair_sort_net and its neighbours
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface pair_sort_net_if #(
  parameter int N     = 8,
  parameter int KEY_W = `DATA_WIDTH,
  parameter int VAL_W = `DATA_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic             in_desc;
  logic [KEY_W-1:0] in_key [N];
  logic [VAL_W-1:0] in_val [N];
  logic             out_valid;
  logic             out_ready;
  logic             out_desc;
  logic [KEY_W-1:0] out_key [N];
  logic [VAL_W-1:0] out_val [N];

  modport slave (
    input  in_valid, in_desc, in_key, in_val, out_ready,
    output in_ready, out_valid, out_desc, out_key, out_val
  );

  modport master (
    output in_valid, in_desc, in_key, in_val, out_ready,
    input  in_ready, out_valid, out_desc, out_key, out_val
  );
endinterface

// File: rtl/pair_sort_net.sv
// rtl/pair_sort_net.sv - pipelined Batcher odd-even merge sorter for N (key, value) pairs
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module pair_sort_net #(
  parameter int N     = 8,
  parameter int KEY_W = `DATA_WIDTH,
  parameter int VAL_W = `DATA_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  pair_sort_net_if.slave       io,
  output logic                 busy
);
  localparam int LG = $clog2(N);
  localparam int S  = LG * (LG + 1) / 2;

  if (N < 2 || N > 64 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("pair_sort_net: N must be a power of two in 2..64");
  end

  // Stage s of the network maps to the (p, k) pair of the iterative Batcher loop.
  function automatic int stage_p(input int s);
    int r   = 1;
    int cnt = 0;
    for (int p = 1; p < N; p = p * 2)
      for (int k = p; k >= 1; k = k / 2) begin
        if (cnt == s) r = p;
        cnt = cnt + 1;
      end
    return r;
  endfunction

  function automatic int stage_k(input int s);
    int r   = 1;
    int cnt = 0;
    for (int p = 1; p < N; p = p * 2)
      for (int k = p; k >= 1; k = k / 2) begin
        if (cnt == s) r = k;
        cnt = cnt + 1;
      end
    return r;
  endfunction

  // True when lane a is the lower lane of a comparator (a, a+k) in stage (p, k).
  function automatic bit is_low(input int a, input int p, input int k);
    int j0;
    j0 = k % p;
    return (a >= j0) && (((a - j0) % (2 * k)) < k) && (a + k < N)
        && ((a / (2 * p)) == ((a + k) / (2 * p)));
  endfunction

  logic             r_valid [S];
  logic             r_desc  [S];
  logic [KEY_W-1:0] r_key   [S][N];
  logic [VAL_W-1:0] r_val   [S][N];

  logic             w_src_valid [S];
  logic             w_src_desc  [S];
  logic [KEY_W-1:0] w_src_key   [S][N];
  logic [VAL_W-1:0] w_src_val   [S][N];
  logic [KEY_W-1:0] w_nxt_key   [S][N];
  logic [VAL_W-1:0] w_nxt_val   [S][N];
  logic             w_adv;

  for (genvar s = 0; s < S; s++) begin : g_stage
    localparam int P = stage_p(s);
    localparam int K = stage_k(s);

    if (s == 0) begin : g_src_in
      // Idle input slots carry zeros so undriven inputs never enter the pipe.
      assign w_src_valid[0] = io.in_valid;
      assign w_src_desc[0]  = io.in_desc & io.in_valid;
      for (genvar l = 0; l < N; l++) begin : g_lane_in
        assign w_src_key[0][l] = io.in_valid ? io.in_key[l] : '0;
        assign w_src_val[0][l] = io.in_valid ? io.in_val[l] : '0;
      end
    end else begin : g_src_reg
      assign w_src_valid[s] = r_valid[s-1];
      assign w_src_desc[s]  = r_desc[s-1];
      assign w_src_key[s]   = r_key[s-1];
      assign w_src_val[s]   = r_val[s-1];
    end

    for (genvar a = 0; a < N; a++) begin : g_lane
      if (is_low(a, P, K)) begin : g_cx
        logic w_swap;
        assign w_swap = w_src_desc[s] ? (w_src_key[s][a] < w_src_key[s][a+K])
                                      : (w_src_key[s][a] > w_src_key[s][a+K]);
        assign w_nxt_key[s][a]   = w_swap ? w_src_key[s][a+K] : w_src_key[s][a];
        assign w_nxt_key[s][a+K] = w_swap ? w_src_key[s][a]   : w_src_key[s][a+K];
        assign w_nxt_val[s][a]   = w_swap ? w_src_val[s][a+K] : w_src_val[s][a];
        assign w_nxt_val[s][a+K] = w_swap ? w_src_val[s][a]   : w_src_val[s][a+K];
      end else if (!(a >= K && is_low(a - K, P, K))) begin : g_pass
        assign w_nxt_key[s][a] = w_src_key[s][a];
        assign w_nxt_val[s][a] = w_src_val[s][a];
      end
    end
  end

  assign w_adv = !r_valid[S-1] || io.out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < S; s++) begin
        r_valid[s] <= 1'b0;
        r_desc[s]  <= 1'b0;
        for (int l = 0; l < N; l++) begin
          r_key[s][l] <= '0;
          r_val[s][l] <= '0;
        end
      end
    end else if (w_adv) begin
      for (int s = 0; s < S; s++) begin
        r_valid[s] <= w_src_valid[s];
        r_desc[s]  <= w_src_desc[s];
        for (int l = 0; l < N; l++) begin
          r_key[s][l] <= w_nxt_key[s][l];
          r_val[s][l] <= w_nxt_val[s][l];
        end
      end
    end
  end

  assign io.in_ready  = w_adv;
  assign io.out_valid = r_valid[S-1];
  assign io.out_desc  = r_desc[S-1];
  assign io.out_key   = r_key[S-1];
  assign io.out_val   = r_val[S-1];

  always_comb begin
    busy = 1'b0;
    for (int s = 0; s < S; s++) busy = busy | r_valid[s];
  end
endmodule

// File: tb/tb_pair_sort_net.sv
// tb/tb_pair_sort_net.sv - directed self-checking bench for pair_sort_net
module tb_pair_sort_net;
  localparam int N  = 8;
  localparam int KW = 16;
  localparam int VW = 8;
  localparam int S  = 6;

  typedef logic [N-1:0][KW-1:0] vec_t;
  typedef struct packed {
    logic desc;
    vec_t sorted;
    vec_t orig;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic busy8, busy2, busy4, busy16;

  always #5 clock = ~clock;

  pair_sort_net_if #(.N(N),  .KEY_W(KW), .VAL_W(VW)) io8 ();
  pair_sort_net_if #(.N(2),  .KEY_W(KW), .VAL_W(VW)) io2 ();
  pair_sort_net_if #(.N(4),  .KEY_W(KW), .VAL_W(VW)) io4 ();
  pair_sort_net_if #(.N(16), .KEY_W(KW), .VAL_W(VW)) io16 ();

  pair_sort_net #(.N(N),  .KEY_W(KW), .VAL_W(VW)) dut8  (.clock(clock), .reset(reset), .io(io8),  .busy(busy8));
  pair_sort_net #(.N(2),  .KEY_W(KW), .VAL_W(VW)) dut2  (.clock(clock), .reset(reset), .io(io2),  .busy(busy2));
  pair_sort_net #(.N(4),  .KEY_W(KW), .VAL_W(VW)) dut4  (.clock(clock), .reset(reset), .io(io4),  .busy(busy4));
  pair_sort_net #(.N(16), .KEY_W(KW), .VAL_W(VW)) dut16 (.clock(clock), .reset(reset), .io(io16), .busy(busy16));

  int n_run  = 0;
  int n_fail = 0;

  int base_keys [N] = '{7, 3, 9, 1, 9, 0, 5, 2};
  int asc_keys  [N] = '{0, 1, 2, 3, 5, 7, 9, 9};
  int desc_keys [N] = '{9, 9, 7, 5, 3, 2, 1, 0};
  int rdy_pat   [8] = '{1, 0, 0, 1, 0, 1, 1, 0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic vec_t ref_sort(input vec_t k, input logic d);
    logic [KW-1:0] t;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N - 1 - i; j++)
        if (d ? (k[j] < k[j+1]) : (k[j] > k[j+1])) begin
          t = k[j]; k[j] = k[j+1]; k[j+1] = t;
        end
    return k;
  endfunction

  function automatic vec_t from_ints(input int a [N]);
    vec_t v;
    for (int l = 0; l < N; l++) v[l] = KW'(a[l]);
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int l = 0; l < N; l++) v[l] = KW'($urandom_range(0, 15));
    return v;
  endfunction

  task automatic drive8(input vec_t k, input logic d);
    for (int l = 0; l < N; l++) begin
      io8.in_key[l] = k[l];
      io8.in_val[l] = VW'(l);
    end
    io8.in_desc  = d;
    io8.in_valid = 1'b1;
  endtask

  task automatic check_out8(input string tag, input vec_t exp_k, input vec_t orig, input logic exp_d);
    check({tag, "_valid"}, 32'(io8.out_valid), 32'd1);
    check({tag, "_desc"}, 32'(io8.out_desc), 32'(exp_d));
    for (int l = 0; l < N; l++) begin
      check($sformatf("%s_key%0d", tag, l), 32'(io8.out_key[l]), 32'(exp_k[l]));
      check($sformatf("%s_pair%0d", tag, l), 32'(orig[io8.out_val[l][2:0]]), 32'(io8.out_key[l]));
    end
  endtask

  task automatic wait_out8(input string tag, input int exp_lat);
    int cnt = 0;
    while (!io8.out_valid && cnt < 40) begin
      @(posedge clock); #1;
      cnt++;
    end
    check(tag, 32'(cnt), 32'(exp_lat));
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  initial begin
    vec_t k1, eq, cur, saved_k;
    logic [N-1:0][VW-1:0] saved_v;
    logic saved_d, prev_stall;
    exp_t exp_q [$];
    exp_t e;
    int sent, got, cnt, nf;

    io8.in_valid = 0; io8.in_desc = 0; io8.out_ready = 1;
    io2.in_valid = 0; io2.in_desc = 0; io2.out_ready = 1;
    io4.in_valid = 0; io4.in_desc = 0; io4.out_ready = 1;
    io16.in_valid = 0; io16.in_desc = 0; io16.out_ready = 1;
    for (int l = 0; l < N; l++) begin io8.in_key[l] = 0; io8.in_val[l] = 0; end
    for (int l = 0; l < 2; l++) begin io2.in_key[l] = 0; io2.in_val[l] = 0; end
    for (int l = 0; l < 4; l++) begin io4.in_key[l] = 0; io4.in_val[l] = 0; end
    for (int l = 0; l < 16; l++) begin io16.in_key[l] = 0; io16.in_val[l] = 0; end

    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", 32'(io8.out_valid), 32'd0);
    check("rst_out_desc", 32'(io8.out_desc), 32'd0);
    check("rst_out_key0", 32'(io8.out_key[0]), 32'd0);
    check("rst_out_key7", 32'(io8.out_key[7]), 32'd0);
    check("rst_out_val3", 32'(io8.out_val[3]), 32'd0);
    check("rst_busy", 32'(busy8), 32'd0);
    reset = 0;
    io8.out_ready = 0;
    tick();
    check("rst_in_ready", 32'(io8.in_ready), 32'd1);
    io8.out_ready = 1;

    k1 = from_ints(base_keys);
    drive8(k1, 1'b0);
    tick();
    io8.in_valid = 0;
    wait_out8("asc_latency", S - 1);
    check_out8("asc", from_ints(asc_keys), k1, 1'b0);
    tick();
    check("asc_drained", 32'(io8.out_valid), 32'd0);

    drive8(k1, 1'b0);
    tick();
    drive8(k1, 1'b1);
    tick();
    io8.in_valid = 0;
    wait_out8("mix_latency", S - 2);
    check_out8("mix_asc", from_ints(asc_keys), k1, 1'b0);
    tick();
    check_out8("mix_desc", from_ints(desc_keys), k1, 1'b1);

    for (int l = 0; l < N; l++) eq[l] = 16'h5;
    drive8(eq, 1'b0);
    tick();
    drive8(eq, 1'b1);
    tick();
    io8.in_valid = 0;
    wait_out8("eq_latency", S - 2);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("eq%0d_desc", d), 32'(io8.out_desc), 32'(d));
      for (int l = 0; l < N; l++) begin
        check($sformatf("eq%0d_key%0d", d, l), 32'(io8.out_key[l]), 32'h5);
        check($sformatf("eq%0d_val%0d", d, l), 32'(io8.out_val[l]), 32'(l));
      end
      tick();
    end

    sent = 0; got = 0; prev_stall = 0;
    saved_k = '0; saved_v = '0; saved_d = 0;
    for (int cyc = 0; cyc < 400 && got < 10; cyc++) begin
      io8.out_ready = rdy_pat[cyc % 8][0];
      if (!io8.in_valid && sent < 10) begin
        cur = rand_vec();
        drive8(cur, 1'($urandom_range(0, 1)));
      end
      #1;
      if (prev_stall) begin
        check("bp_stall_valid", 32'(io8.out_valid), 32'd1);
        check("bp_stall_desc", 32'(io8.out_desc), 32'(saved_d));
        for (int l = 0; l < N; l++) begin
          check("bp_stall_key", 32'(io8.out_key[l]), 32'(saved_k[l]));
          check("bp_stall_val", 32'(io8.out_val[l]), 32'(saved_v[l]));
        end
      end
      check("bp_in_ready", 32'(io8.in_ready), 32'(!io8.out_valid || io8.out_ready));
      if (io8.out_valid && io8.out_ready) begin
        if (exp_q.size() == 0) begin
          check("bp_unexpected_out", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_out8($sformatf("bp%0d", got), e.sorted, e.orig, e.desc);
        end
        got++;
      end
      prev_stall = io8.out_valid && !io8.out_ready;
      saved_d = io8.out_desc;
      for (int l = 0; l < N; l++) begin
        saved_k[l] = io8.out_key[l];
        saved_v[l] = io8.out_val[l];
      end
      if (io8.in_valid && io8.in_ready) begin
        e.orig   = cur;
        e.desc   = io8.in_desc;
        e.sorted = ref_sort(cur, io8.in_desc);
        exp_q.push_back(e);
        sent++;
        tick();
        io8.in_valid = 0;
      end else begin
        tick();
      end
      #0;
      if (cyc >= 0) begin end
      #(-0);
    end
    check("bp_count", 32'(got), 32'd10);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
    io8.out_ready = 1;

    for (int v = 0; v < 4; v++) begin
      drive8(rand_vec(), 1'b0);
      tick();
    end
    io8.in_valid = 0;
    reset = 1;
    #1;
    check("mrst_out_valid", 32'(io8.out_valid), 32'd0);
    check("mrst_busy", 32'(busy8), 32'd0);
    @(posedge clock); #1;
    reset = 0;
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (io8.out_valid) cnt++;
      tick();
    end
    check("mrst_no_output", 32'(cnt), 32'd0);
    drive8(k1, 1'b0);
    tick();
    io8.in_valid = 0;
    wait_out8("mrst_latency", S - 1);
    check_out8("mrst", from_ints(asc_keys), k1, 1'b0);
    tick();

    io2.in_key[0] = 16'hFFFF; io2.in_key[1] = 16'h0000;
    io2.in_val[0] = 0; io2.in_val[1] = 1;
    io2.in_valid = 1;
    tick();
    io2.in_valid = 0;
    cnt = 0;
    while (!io2.out_valid && cnt < 40) begin tick(); cnt++; end
    check("n2_latency", 32'(cnt), 32'd0);
    check("n2_key0", 32'(io2.out_key[0]), 32'h0000);
    check("n2_key1", 32'(io2.out_key[1]), 32'hFFFF);
    check("n2_val0", 32'(io2.out_val[0]), 32'd1);

    io4.in_key[0] = 16'hFFFF; io4.in_key[1] = 16'h0000;
    io4.in_key[2] = 16'h8000; io4.in_key[3] = 16'h0001;
    for (int l = 0; l < 4; l++) io4.in_val[l] = VW'(l);
    io4.in_valid = 1;
    tick();
    io4.in_valid = 0;
    cnt = 0;
    while (!io4.out_valid && cnt < 40) begin tick(); cnt++; end
    check("n4_latency", 32'(cnt), 32'd2);
    check("n4_key0", 32'(io4.out_key[0]), 32'h0000);
    check("n4_key1", 32'(io4.out_key[1]), 32'h0001);
    check("n4_key2", 32'(io4.out_key[2]), 32'h8000);
    check("n4_key3", 32'(io4.out_key[3]), 32'hFFFF);
    check("n4_val3", 32'(io4.out_val[3]), 32'd0);

    nf = 0;
    for (int l = 0; l < 16; l++) begin
      io16.in_key[l] = (l % 3 == 0) ? 16'hFFFF : 16'h0000;
      io16.in_val[l] = VW'(l);
      if (l % 3 == 0) nf++;
    end
    io16.in_valid = 1;
    tick();
    io16.in_valid = 0;
    cnt = 0;
    while (!io16.out_valid && cnt < 40) begin tick(); cnt++; end
    check("n16_latency", 32'(cnt), 32'd9);
    for (int l = 0; l < 16; l++) begin
      check($sformatf("n16_key%0d", l), 32'(io16.out_key[l]), (l >= 16 - nf) ? 32'hFFFF : 32'h0);
      check($sformatf("n16_pair%0d", l), 32'(io16.out_val[l] % 3 == 0), 32'(l >= 16 - nf));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
